apbspi_apb_master: RTL

//   APB initiator: turns a simple valid/ready command stream into APB

---
 rtl/apbspi_apb_master_if.sv | 15 +
 rtl/apbspi_apb_master.sv | 84 ++++++++
 2 files changed

// File: rtl/apbspi_apb_master_if.sv
// apbspi_apb_if: APB bus between the initiator and the SPI peripheral
interface apbspi_apb_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [31:0]           pwdata;
  logic [31:0]           prdata;
  logic                  pready;
  logic                  pslverr;
  modport master (output paddr, psel, penable, pwrite, pwdata, input prdata, pready, pslverr);
  modport slave (input paddr, psel, penable, pwrite, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/apbspi_apb_master.sv
// apbspi_apb_master: command/response stream to APB SETUP/ACCESS transfers with ACCESS timeout
module apbspi_apb_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [31:0]           cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  apbspi_apb_if.master          apb
);
  localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [31:0]           pwdata_q, pwdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  accept, done, tmo;
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q       <= IDLE;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      cnt_q         <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      cnt_q         <= cnt_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
  // pready wins over a timeout landing in the same cycle
  always_comb begin
    accept  = state_q == IDLE && cmd_valid;
    done    = state_q == ACCESS && apb.pready;
    tmo     = TIMEOUT_CYCLES != 0 && state_q == ACCESS && !apb.pready && cnt_q == CW'(TIMEOUT_CYCLES - 1);
    state_d = state_q == IDLE   ? (cmd_valid ? SETUP : IDLE) :
              state_q == SETUP  ? ACCESS :
              state_q == ACCESS ? ((done || tmo) ? RESP : ACCESS) :
                                  (rsp_ready ? IDLE : RESP);
  end
  always_comb begin
    paddr_d       = accept ? cmd_addr : paddr_q;
    pwrite_d      = accept ? cmd_write : pwrite_q;
    pwdata_d      = accept ? (cmd_write ? cmd_wdata : 32'h0) : pwdata_q;
    cnt_d         = state_q == SETUP ? '0 :
                    (state_q == ACCESS && !apb.pready && cnt_q != '1) ? cnt_q + CW'(1) : cnt_q;
    rsp_rdata_d   = done ? (pwrite_q ? 32'h0 : apb.prdata) : tmo ? 32'h0 : rsp_rdata_q;
    rsp_err_d     = done ? apb.pslverr : (tmo | rsp_err_q);
    rsp_timeout_d = done ? 1'b0 : (tmo | rsp_timeout_q);
  end
  always_comb begin
    cmd_ready   = state_q == IDLE;
    rsp_valid   = state_q == RESP;
    rsp_rdata   = rsp_rdata_q;
    rsp_err     = rsp_err_q;
    rsp_timeout = rsp_timeout_q;
    apb.psel    = state_q == SETUP || state_q == ACCESS;
    apb.penable = state_q == ACCESS;
    apb.paddr   = paddr_q;
    apb.pwrite  = pwrite_q;
    apb.pwdata  = pwdata_q;
  end
endmodule
